// File: rtl/cpu_div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package cpu_div_pkg;

   localparam int unsigned DIV_ITER  = 32;
   localparam int unsigned CNT_W     = 5;
   localparam logic [31:0] DIVZERO_Q = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } div_state_e;

endpackage

// File: rtl/sub32.sv
// 32-bit subtractor: diff = a - b, cout is the borrow (1 when a < b unsigned).
module sub32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] diff,
   output logic        cout
);

   logic [32:0] full;

   assign full = {1'b0, a} - {1'b0, b};
   assign diff = full[31:0];
   assign cout = full[32];

endmodule

// File: rtl/div32_seq.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
// The remainder takes the sign of the dividend and the quotient truncates toward zero.
module div32_seq
   import cpu_div_pkg::*;
#(
   parameter int unsigned WIDTH        = 32,
   parameter bit          DIVZERO_FAST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   div_state_e       state;
   logic [WIDTH-1:0] rem_acc;
   logic [WIDTH-1:0] quo_acc;
   logic [WIDTH-1:0] dsor;
   logic [CNT_W-1:0] count;
   logic             q_neg;
   logic             r_neg;
   logic             dz;

   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             qbit;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;
   logic [WIDTH-1:0] q_fix;
   logic [WIDTH-1:0] r_src;
   logic [WIDTH-1:0] r_fix;

   assign shifted = {rem_acc[WIDTH-2:0], quo_acc[WIDTH-1]};

   sub32 u_sub32 (
      .a    (shifted),
      .b    (dsor),
      .diff (diff),
      .cout (borrow)
   );

   // A set R[31] means the shifted value exceeds 2^32 > D, so the subtraction always fits.
   assign qbit = rem_acc[WIDTH-1] | ~borrow;

   assign dividend_mag = (div_signed && dividend[WIDTH-1]) ? (~dividend + WIDTH'(1)) : dividend;
   assign divisor_mag  = (div_signed && divisor[WIDTH-1])  ? (~divisor + WIDTH'(1))  : divisor;

   // On a fast divide-by-zero the dividend magnitude never left the quotient accumulator.
   assign q_fix = q_neg ? (~quo_acc + WIDTH'(1)) : quo_acc;
   assign r_src = (dz && DIVZERO_FAST) ? quo_acc : rem_acc;
   assign r_fix = r_neg ? (~r_src + WIDTH'(1)) : r_src;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         rem_acc     <= '0;
         quo_acc     <= '0;
         dsor        <= '0;
         count       <= '0;
         q_neg       <= 1'b0;
         r_neg       <= 1'b0;
         dz          <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  rem_acc <= '0;
                  quo_acc <= dividend_mag;
                  dsor    <= divisor_mag;
                  count   <= CNT_W'(DIV_ITER - 1);
                  q_neg   <= div_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  r_neg   <= div_signed & dividend[WIDTH-1];
                  dz      <= (divisor == '0);
                  busy    <= 1'b1;
                  state   <= ((divisor == '0) && DIVZERO_FAST) ? FIXUP : RUN;
               end
            end
            RUN: begin
               quo_acc <= {quo_acc[WIDTH-2:0], qbit};
               rem_acc <= qbit ? diff : shifted;
               count   <= count - CNT_W'(1);
               if (count == '0) begin
                  state <= FIXUP;
               end
            end
            FIXUP: begin
               quotient    <= dz ? DIVZERO_Q : q_fix;
               remainder   <= r_fix;
               div_by_zero <= dz;
               busy        <= 1'b0;
               done        <= 1'b1;
               state       <= DONE;
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
